mips_issue_ctrl: RTL and testbench
==================================

Name: mips_issue_ctrl

Overview:
- Sequential issue/hazard controller between instruction decode and the 32-bit control-word datapath (ALU, multiplier, data memory, register file).
- Tracks in-flight destination registers across the EX/MEM/WB stages and holds decode on RAW hazards and on the multi-cycle multiplier.
- Drives a writeback tag stream to the register file.

Parameters:
- DEPTH, 3, in-flight stages tracked; stage 0 = EX, DEPTH-1 = WB; legal range 2..8.
- MUL_LAT, 3, cycles MUL occupies EX; legal range 1..15; 1 = no extra cycles.
- CNT_W, 16, width of the stall counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  decode presents instr.
- instr  in  32  instruction word.
- in_ready  out  1  = !stall; instr accepted when in_valid && in_ready.
- iss_valid  out  1  registered; high the cycle after acceptance.
- iss_rd  out  5  registered destination (0 = none).
- iss_mul  out  1  registered; issued op is MUL.
- iss_fwd_a  out  2  registered rs source: 0 regfile, 1 from MEM, 2 from WB.
- iss_fwd_b  out  2  registered rt source, same codes as iss_fwd_a.
- stall  out  1  combinational; = hazard_raw | hazard_mul.
- hazard_raw  out  1  combinational RAW hazard.
- hazard_mul  out  1  combinational multiplier busy.
- illegal  out  1  registered one-cycle pulse on an accepted unknown opcode/funct.
- wb_valid  out  1  stage DEPTH-1 entry has a valid write.
- wb_rd  out  5  stage DEPTH-1 destination.
- stall_cnt  out  CNT_W  saturating count of cycles with in_valid && stall.

Behaviour:
- Decode fields:
  - op=15 (R-type): sources rs, rt; dest rd. funct 32 ADD, 34 SUB, 36 AND, 37 OR, 50 MUL.
  - op=16 (LW): source rs; dest rt; flagged load.
  - op=17 (SW): sources rs, rt; no dest.
  - Any other op or funct: NOP with no sources and no dest; raises illegal.
- Register 0 as a dest is stored as 0 and never matches a source.
- Stage array: per stage {valid, rd, is_load}.
- Advance cycle (mul_cnt==0):
  - Stages shift toward WB.
  - Stage 0 loads the accepted instr's entry, or a bubble if none was accepted.
- Freeze (mul_cnt!=0): stages hold, mul_cnt decrements, hazard_mul=1, nothing accepted.
- Acceptance of a MUL loads mul_cnt=MUL_LAT-1 on the same edge that places it in stage 0.
- RAW hazard (no forwarding): any valid stage whose rd equals a used source.
- stall=1 gates acceptance. stall is still evaluated while in_valid=0; hazard flags are meaningful only with in_valid.
- The iss_* outputs are valid only while iss_valid=1 and are zeroed otherwise.
- Simultaneous RAW and MUL: both flags high; stall_cnt increments once.
- stall_cnt holds at 2^CNT_W-1.
- Reset (asserted at any time, including mid-MUL):
  - All stages invalid; mul_cnt=0.
  - All registered outputs 0; stall_cnt=0.
  - in_ready=1 after release.

Optional Feature:
- Macro: MIPS_ISSUE_FWD_EN.
- When defined:
  - A match in stage 0 (EX) sets fwd=1, unless that entry is_load, in which case hazard_raw=1 (load-use, one bubble).
  - A match in stage 1 sets fwd=2.
  - Matches in stages >=2 are ignored; the value is already in the regfile.
  - When both match, the youngest stage wins.
- When undefined: iss_fwd_a/b tied to 0 and the full RAW rule above applies.

Decomposition:
- Package mips_pkg:
  - Opcode constants OP_RTYPE=15, OP_LW=16, OP_SW=17.
  - Funct constants F_ADD=32, F_SUB=34, F_AND=36, F_OR=37, F_MUL=50.
  - Stage-entry struct typedef.
- One sub-module, mips_src_decode: combinational decode of instr to {uses_rs, uses_rt, rd, is_load, is_mul, illegal}.

Test Plan:
- ADD r3,r1,r2 (0x3C221820) then independent ADD r6,r4,r5 (0x3C853020) -> both issue back-to-back, stall never high, wb_rd=3 then 6 at cycles DEPTH and DEPTH+1.
- 0x3C221820 then ADD r7,r3,r3 (0x3C633820):
  - without FWD: stall for 3 cycles, stall_cnt=3.
  - with FWD: no stall, iss_fwd_a=iss_fwd_b=1.
- LW r4,0(r3) (0x40640000) then ADD r8,r4,r4 (0x3C844020) with FWD -> exactly one stall cycle, then iss_fwd_a=2.
- MUL r5,r1,r2 (0x3C222832), MUL_LAT=3 -> hazard_mul high for 2 cycles after issue; stages frozen; wb_rd=5 reached after DEPTH+2 cycles.
- Opcode 63 (0xFC000000) -> issues, illegal pulses one cycle, iss_rd=0; ADD r0,r1,r2 then a reader of r0 -> no stall.
- Assert rst during the MUL freeze -> stall=0, wb_valid=0, stall_cnt=0 immediately; next instr accepted the first cycle after release.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared opcode/funct constants and the per-stage scoreboard entry used by
// the issue controller and its decoder.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd15;
    localparam logic [5:0] OP_LW    = 6'd16;
    localparam logic [5:0] OP_SW    = 6'd17;

    localparam logic [5:0] F_ADD = 6'd32;
    localparam logic [5:0] F_SUB = 6'd34;
    localparam logic [5:0] F_AND = 6'd36;
    localparam logic [5:0] F_OR  = 6'd37;
    localparam logic [5:0] F_MUL = 6'd50;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_e;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       is_load;
    } stage_t;

    // An entry is only valid when it writes a non-zero register, so r0 never hits.
    function automatic logic src_hit(stage_t s, logic used, logic [4:0] r);
        return used && s.valid && (s.rd == r);
    endfunction

endpackage

// File: rtl/mips_src_decode.sv
// Combinational instruction decode: which sources are read, which register
// is written, and whether the op is a load, a multiply or unrecognised.
module mips_src_decode
    import mips_pkg::*;
(
    input  logic [31:0] instr_i,
    output logic        uses_rs_o,
    output logic        uses_rt_o,
    output logic [4:0]  rd_o,
    output logic        is_load_o,
    output logic        is_mul_o,
    output logic        illegal_o
);

    logic [5:0] op;
    logic [5:0] funct;
    logic       unused_shamt;

    assign op           = instr_i[31:26];
    assign funct        = instr_i[5:0];
    assign unused_shamt = ^instr_i[10:6];

    always_comb begin
        uses_rs_o = 1'b0;
        uses_rt_o = 1'b0;
        rd_o      = '0;
        is_load_o = 1'b0;
        is_mul_o  = 1'b0;
        illegal_o = 1'b0;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    F_ADD, F_SUB, F_AND, F_OR, F_MUL: begin
                        uses_rs_o = 1'b1;
                        uses_rt_o = 1'b1;
                        rd_o      = instr_i[15:11];
                        is_mul_o  = (funct == F_MUL);
                    end
                    default: illegal_o = 1'b1;
                endcase
            end
            OP_LW: begin
                uses_rs_o = 1'b1;
                rd_o      = instr_i[20:16];
                is_load_o = 1'b1;
            end
            OP_SW: begin
                uses_rs_o = 1'b1;
                uses_rt_o = 1'b1;
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/mips_issue_ctrl.sv
// Issue/hazard controller: tracks in-flight destinations over DEPTH stages,
// holds decode on RAW hazards and multiplier occupancy. Optional forwarding
// is enabled by defining MIPS_ISSUE_FWD_EN.
module mips_issue_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH   = 3,
    parameter int unsigned MUL_LAT = 3,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [31:0]      instr,
    output logic             in_ready,
    output logic             iss_valid,
    output logic [4:0]       iss_rd,
    output logic             iss_mul,
    output logic [1:0]       iss_fwd_a,
    output logic [1:0]       iss_fwd_b,
    output logic             stall,
    output logic             hazard_raw,
    output logic             hazard_mul,
    output logic             illegal,
    output logic             wb_valid,
    output logic [4:0]       wb_rd,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [3:0] MUL_RELOAD = 4'(MUL_LAT - 1);

    logic       dec_uses_rs;
    logic       dec_uses_rt;
    logic [4:0] dec_rd;
    logic       dec_is_load;
    logic       dec_is_mul;
    logic       dec_illegal;
    logic [4:0] rs;
    logic [4:0] rt;

    stage_t     stg_q [DEPTH];
    stage_t     stg_d [DEPTH];
    stage_t     new_entry;
    logic [3:0] mul_cnt_q, mul_cnt_d;

    logic             iss_valid_q, iss_valid_d;
    logic [4:0]       iss_rd_q, iss_rd_d;
    logic             iss_mul_q, iss_mul_d;
    logic [1:0]       iss_fwd_a_q, iss_fwd_a_d;
    logic [1:0]       iss_fwd_b_q, iss_fwd_b_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic raw;
    logic accept;
    fwd_e fwd_a;
    fwd_e fwd_b;

    mips_src_decode u_dec (
        .instr_i   (instr),
        .uses_rs_o (dec_uses_rs),
        .uses_rt_o (dec_uses_rt),
        .rd_o      (dec_rd),
        .is_load_o (dec_is_load),
        .is_mul_o  (dec_is_mul),
        .illegal_o (dec_illegal)
    );

    assign rs = instr[25:21];
    assign rt = instr[20:16];

`ifdef MIPS_ISSUE_FWD_EN
    logic hit0_a, hit0_b, hit1_a, hit1_b;

    // Only EX and MEM can be bypassed; older stages are already in the regfile.
    always_comb begin
        hit0_a = src_hit(stg_q[0], dec_uses_rs, rs);
        hit0_b = src_hit(stg_q[0], dec_uses_rt, rt);
        hit1_a = src_hit(stg_q[1], dec_uses_rs, rs);
        hit1_b = src_hit(stg_q[1], dec_uses_rt, rt);
        raw    = (hit0_a || hit0_b) && stg_q[0].is_load;
        fwd_a  = hit0_a ? FWD_MEM : (hit1_a ? FWD_WB : FWD_RF);
        fwd_b  = hit0_b ? FWD_MEM : (hit1_b ? FWD_WB : FWD_RF);
    end
`else
    always_comb begin
        raw   = 1'b0;
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (src_hit(stg_q[i], dec_uses_rs, rs) || src_hit(stg_q[i], dec_uses_rt, rt))
                raw = 1'b1;
        end
    end
`endif

    assign hazard_raw = raw;
    assign hazard_mul = (mul_cnt_q != '0);
    assign stall      = hazard_raw || hazard_mul;
    assign in_ready   = !stall;
    assign accept     = in_valid && !stall;

    always_comb begin
        new_entry.valid   = (dec_rd != '0);
        new_entry.rd      = dec_rd;
        new_entry.is_load = dec_is_load;
    end

    always_comb begin
        stg_d     = stg_q;
        mul_cnt_d = mul_cnt_q;
        if (mul_cnt_q != '0) begin
            mul_cnt_d = mul_cnt_q - 4'd1;
        end else begin
            for (int unsigned i = 1; i < DEPTH; i++)
                stg_d[i] = stg_q[i-1];
            stg_d[0] = accept ? new_entry : '0;
            if (accept && dec_is_mul)
                mul_cnt_d = MUL_RELOAD;
        end
    end

    always_comb begin
        iss_valid_d = accept;
        iss_rd_d    = accept ? dec_rd : '0;
        iss_mul_d   = accept && dec_is_mul;
        iss_fwd_a_d = accept ? fwd_a : FWD_RF;
        iss_fwd_b_d = accept ? fwd_b : FWD_RF;
        illegal_d   = accept && dec_illegal;
        stall_cnt_d = stall_cnt_q;
        if (in_valid && stall && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                stg_q[i] <= '0;
            mul_cnt_q   <= '0;
            iss_valid_q <= 1'b0;
            iss_rd_q    <= '0;
            iss_mul_q   <= 1'b0;
            iss_fwd_a_q <= '0;
            iss_fwd_b_q <= '0;
            illegal_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            stg_q       <= stg_d;
            mul_cnt_q   <= mul_cnt_d;
            iss_valid_q <= iss_valid_d;
            iss_rd_q    <= iss_rd_d;
            iss_mul_q   <= iss_mul_d;
            iss_fwd_a_q <= iss_fwd_a_d;
            iss_fwd_b_q <= iss_fwd_b_d;
            illegal_q   <= illegal_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign iss_valid = iss_valid_q;
    assign iss_rd    = iss_rd_q;
    assign iss_mul   = iss_mul_q;
    assign iss_fwd_a = iss_fwd_a_q;
    assign iss_fwd_b = iss_fwd_b_q;
    assign illegal   = illegal_q;
    assign stall_cnt = stall_cnt_q;
    assign wb_valid  = stg_q[DEPTH-1].valid;
    assign wb_rd     = stg_q[DEPTH-1].rd;

endmodule

// File: tb/tb_mips_issue_ctrl.sv
// Scoreboard bench for mips_issue_ctrl: expected issue records are queued at
// acceptance and compared when iss_valid appears; hazards/wb checked inline.
module tb_mips_issue_ctrl;

    localparam int DEPTH   = 3;
    localparam int MUL_LAT = 3;
    localparam int CNT_W   = 16;
`ifdef MIPS_ISSUE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct {
        logic [4:0] rd;
        logic       mul;
        logic [1:0] fa;
        logic [1:0] fb;
        logic       ill;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic [31:0]      instr = '0;
    logic             in_ready, iss_valid, iss_mul, stall, hazard_raw, hazard_mul;
    logic             illegal, wb_valid;
    logic [4:0]       iss_rd, wb_rd;
    logic [1:0]       iss_fwd_a, iss_fwd_b;
    logic [CNT_W-1:0] stall_cnt;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t sbq[$];
    exp_t mon_e;

    mips_issue_ctrl #(.DEPTH(DEPTH), .MUL_LAT(MUL_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .instr(instr),
        .in_ready(in_ready), .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_mul(iss_mul),
        .iss_fwd_a(iss_fwd_a), .iss_fwd_b(iss_fwd_b), .stall(stall),
        .hazard_raw(hazard_raw), .hazard_mul(hazard_mul), .illegal(illegal),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Issue monitor: pops the scoreboard on every iss_valid, requires zeros otherwise.
    always @(negedge clk) begin
        if (!rst) begin
            total++;
            if (iss_valid === 1'b1) begin
                if (sbq.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_issue got rd=%0d with empty scoreboard", iss_rd);
                end else begin
                    mon_e = sbq.pop_front();
                    if ({iss_rd, iss_mul, iss_fwd_a, iss_fwd_b, illegal} !==
                        {mon_e.rd, mon_e.mul, mon_e.fa, mon_e.fb, mon_e.ill}) begin
                        bad++;
                        $display("FAIL issue_fields got rd=%0d mul=%b fa=%0d fb=%0d ill=%b need rd=%0d mul=%b fa=%0d fb=%0d ill=%b",
                                 iss_rd, iss_mul, iss_fwd_a, iss_fwd_b, illegal,
                                 mon_e.rd, mon_e.mul, mon_e.fa, mon_e.fb, mon_e.ill);
                    end
                end
            end else if ({iss_rd, iss_mul, iss_fwd_a, iss_fwd_b, illegal} !== 11'd0) begin
                bad++;
                $display("FAIL idle_zero got %b need 0", {iss_rd, iss_mul, iss_fwd_a, iss_fwd_b, illegal});
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sbq.delete();
    endtask

    // Presents ins until accepted; pushes the expected record on the accepting cycle.
    task automatic issue(input logic [31:0] ins, input logic [4:0] rd, input logic mul,
                         input logic [1:0] fa, input logic [1:0] fb, input logic ill,
                         output int stalls, output int hmul, output int acc);
        exp_t e;
        stalls = 0;
        hmul = 0;
        acc = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            instr = ins;
            #1;
            if (in_ready === 1'b1) begin
                e.rd = rd; e.mul = mul; e.fa = fa; e.fb = fb; e.ill = ill;
                sbq.push_back(e);
                acc = cyc + 1;
                return;
            end
            stalls++;
            if (hazard_mul === 1'b1) hmul++;
        end
        total++;
        bad++;
        $display("FAIL accept_timeout instr=%h waited=%0d need <40", ins, stalls);
        in_valid = 1'b0;
    endtask

    task automatic wait_cyc(input int target);
        for (int g = 0; g < 100 && cyc < target; g++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        total++;
        if ({in_ready, stall, hazard_raw, hazard_mul} !== 4'b1000) begin
            bad++;
            $display("FAIL reset_hazards got %b need 1000", {in_ready, stall, hazard_raw, hazard_mul});
        end
        total++;
        if ({iss_valid, illegal, wb_valid, wb_rd, stall_cnt} !== '0) begin
            bad++;
            $display("FAIL reset_regs got v=%b ill=%b wbv=%b wbrd=%0d cnt=%0d need all 0",
                     iss_valid, illegal, wb_valid, wb_rd, stall_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int s1, s2, h, a1, a2;
        do_reset();
        issue(32'h3C221820, 5'd3, 1'b0, 2'd0, 2'd0, 1'b0, s1, h, a1);
        issue(32'h3C853020, 5'd6, 1'b0, 2'd0, 2'd0, 1'b0, s2, h, a2);
        total++;
        if (s1 + s2 !== 0) begin bad++; $display("FAIL b2b_stalls got %0d need 0", s1 + s2); end
        total++;
        if (a2 !== a1 + 1) begin bad++; $display("FAIL b2b_adjacent got gap %0d need 1", a2 - a1); end
        wait_cyc(a1 + DEPTH - 1);
        total++;
        if ({wb_valid, wb_rd} !== {1'b1, 5'd3}) begin
            bad++; $display("FAIL b2b_wb1 got v=%b rd=%0d need v=1 rd=3", wb_valid, wb_rd);
        end
        wait_cyc(a1 + DEPTH);
        total++;
        if ({wb_valid, wb_rd} !== {1'b1, 5'd6}) begin
            bad++; $display("FAIL b2b_wb2 got v=%b rd=%0d need v=1 rd=6", wb_valid, wb_rd);
        end
    endtask

    task automatic test_raw();
        int s1, s2, h, a1, a2;
        do_reset();
        issue(32'h3C221820, 5'd3, 1'b0, 2'd0, 2'd0, 1'b0, s1, h, a1);
        issue(32'h3C633820, 5'd7, 1'b0, FWD ? 2'd1 : 2'd0, FWD ? 2'd1 : 2'd0, 1'b0, s2, h, a2);
        total++;
        if (s2 !== (FWD ? 0 : DEPTH)) begin
            bad++; $display("FAIL raw_stalls got %0d need %0d", s2, FWD ? 0 : DEPTH);
        end
        wait_cyc(a2);
        total++;
        if (stall_cnt !== CNT_W'(FWD ? 0 : DEPTH)) begin
            bad++; $display("FAIL raw_stall_cnt got %0d need %0d", stall_cnt, FWD ? 0 : DEPTH);
        end
    endtask

    task automatic test_load_use();
        int s1, s2, h, a1, a2;
        do_reset();
        issue(32'h40640000, 5'd4, 1'b0, 2'd0, 2'd0, 1'b0, s1, h, a1);
        issue(32'h3C844020, 5'd8, 1'b0, FWD ? 2'd2 : 2'd0, FWD ? 2'd2 : 2'd0, 1'b0, s2, h, a2);
        total++;
        if (s2 !== (FWD ? 1 : DEPTH)) begin
            bad++; $display("FAIL load_use_stalls got %0d need %0d", s2, FWD ? 1 : DEPTH);
        end
        wait_cyc(a2);
        total++;
        if (stall_cnt !== CNT_W'(FWD ? 1 : DEPTH)) begin
            bad++; $display("FAIL load_use_cnt got %0d need %0d", stall_cnt, FWD ? 1 : DEPTH);
        end
    endtask

    task automatic test_mul();
        int s1, s2, h1, h2, a1, a2;
        do_reset();
        issue(32'h3C222832, 5'd5, 1'b1, 2'd0, 2'd0, 1'b0, s1, h1, a1);
        issue(32'h3C813120, 5'd6, 1'b0, 2'd0, 2'd0, 1'b0, s2, h2, a2);
        total++;
        if ({s2, h2} !== {MUL_LAT - 1, MUL_LAT - 1}) begin
            bad++; $display("FAIL mul_freeze got stalls=%0d hmul=%0d need %0d each", s2, h2, MUL_LAT - 1);
        end
        wait_cyc(a1 + DEPTH + MUL_LAT - 3);
        total++;
        if ({wb_valid, stall_cnt} !== {1'b0, CNT_W'(MUL_LAT - 1)}) begin
            bad++; $display("FAIL mul_frozen got wbv=%b cnt=%0d need wbv=0 cnt=%0d", wb_valid, stall_cnt, MUL_LAT - 1);
        end
        wait_cyc(a1 + DEPTH + MUL_LAT - 2);
        total++;
        if ({wb_valid, wb_rd} !== {1'b1, 5'd5}) begin
            bad++; $display("FAIL mul_wb got v=%b rd=%0d need v=1 rd=5", wb_valid, wb_rd);
        end
        wait_cyc(a2 + DEPTH - 1);
        total++;
        if ({wb_valid, wb_rd} !== {1'b1, 5'd6}) begin
            bad++; $display("FAIL mul_next_wb got v=%b rd=%0d need v=1 rd=6", wb_valid, wb_rd);
        end
    endtask

    task automatic test_illegal_r0();
        int s1, s2, s3, s4, h, a1, a2, a3, a4;
        do_reset();
        issue(32'hFC000000, 5'd0, 1'b0, 2'd0, 2'd0, 1'b1, s1, h, a1);
        issue(32'h3C000000, 5'd0, 1'b0, 2'd0, 2'd0, 1'b1, s2, h, a2);
        issue(32'h3C220020, 5'd0, 1'b0, 2'd0, 2'd0, 1'b0, s3, h, a3);
        issue(32'h3C004820, 5'd9, 1'b0, 2'd0, 2'd0, 1'b0, s4, h, a4);
        total++;
        if (s1 + s2 + s3 + s4 !== 0) begin
            bad++; $display("FAIL r0_stalls got %0d need 0", s1 + s2 + s3 + s4);
        end
        wait_cyc(a3 + DEPTH - 1);
        total++;
        if (wb_valid !== 1'b0) begin bad++; $display("FAIL r0_wb_valid got %b need 0", wb_valid); end
        wait_cyc(a4 + DEPTH - 1);
        total++;
        if ({wb_valid, wb_rd} !== {1'b1, 5'd9}) begin
            bad++; $display("FAIL r0_reader_wb got v=%b rd=%0d need v=1 rd=9", wb_valid, wb_rd);
        end
    endtask

    task automatic test_reset_mid_mul();
        int s1, h, a1;
        exp_t e;
        do_reset();
        issue(32'h3C222832, 5'd5, 1'b1, 2'd0, 2'd0, 1'b0, s1, h, a1);
        @(negedge clk);
        in_valid = 1'b1;
        instr = 32'h3C813120;
        #1;
        total++;
        if ({hazard_mul, stall, in_ready} !== 3'b110) begin
            bad++; $display("FAIL rmm_freeze got %b need 110", {hazard_mul, stall, in_ready});
        end
        @(negedge clk);
        total++;
        if (stall_cnt !== CNT_W'(1)) begin bad++; $display("FAIL rmm_cnt_pre got %0d need 1", stall_cnt); end
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        total++;
        if ({stall, wb_valid, stall_cnt, hazard_mul, in_ready} !== {3'b000, CNT_W'(0), 2'b01}) begin
            bad++; $display("FAIL rmm_reset got stall=%b wbv=%b cnt=%0d hmul=%b rdy=%b need 0 0 0 0 1",
                            stall, wb_valid, stall_cnt, hazard_mul, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b1;
        instr = 32'h3C813120;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL rmm_accept got in_ready=%b need 1", in_ready);
        end else begin
            e.rd = 5'd6; e.mul = 1'b0; e.fa = 2'd0; e.fb = 2'd0; e.ill = 1'b0;
            sbq.push_back(e);
        end
        repeat (3) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_raw();
        test_load_use();
        test_mul();
        test_illegal_r0();
        test_reset_mid_mul();
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (sbq.size() !== 0) begin
            bad++; $display("FAIL scoreboard_drain got %0d pending need 0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
